// File: rtl/lcd_nibble_tx_if.sv
// Request/status handshake between the LCD command sequencer and the nibble transmitter.
interface lcd_nibble_tx_if;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_rs;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start,
        output tx_byte,
        output tx_rs,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_byte,
        input  tx_rs,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/lcd_nibble_tx.sv
// Sends one byte to an HD44780 LCD as two 4-bit writes with the required setup,
// enable, hold, inter-nibble and post-byte delays.
module lcd_nibble_tx #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned EN_CYC    = 12,
    parameter int unsigned HOLD_CYC  = 1,
    parameter int unsigned GAP_CYC   = 50,
    parameter int unsigned WAIT_CYC  = 2000,
    parameter int unsigned CNT_W     = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    lcd_nibble_tx_if.slave         tx,
    output logic                   LCD_RS,
    output logic                   LCD_RW,
    output logic                   LCD_EN,
    output logic [3:0]             LCD_SF_D
);

    typedef enum logic [3:0] {
        StIdle,
        StUpSetup,
        StUpEn,
        StUpHold,
        StGap,
        StLoSetup,
        StLoEn,
        StLoHold,
        StWait
    } state_e;

    // Counter is loaded with duration-1 on entry so each state lasts exactly *_CYC cycles.
    localparam logic [CNT_W-1:0] LdSetup = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LdEn    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] LdHold  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LdGap   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] LdWait  = CNT_W'(WAIT_CYC - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       lo_nib_q;
    logic [3:0]       sf_d_q;
    logic             rs_q;
    logic             en_q;
    logic             busy_q;
    logic             done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            lo_nib_q <= '0;
            sf_d_q   <= '0;
            rs_q     <= 1'b0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == StIdle) begin
                if (tx.tx_start) begin
                    state_q  <= StUpSetup;
                    cnt_q    <= LdSetup;
                    busy_q   <= 1'b1;
                    rs_q     <= tx.tx_rs;
                    sf_d_q   <= tx.tx_byte[7:4];
                    lo_nib_q <= tx.tx_byte[3:0];
                end
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end else begin
                case (state_q)
                    StUpSetup: begin
                        state_q <= StUpEn;
                        cnt_q   <= LdEn;
                        en_q    <= 1'b1;
                    end
                    StUpEn: begin
                        state_q <= StUpHold;
                        cnt_q   <= LdHold;
                        en_q    <= 1'b0;
                    end
                    StUpHold: begin
                        state_q <= StGap;
                        cnt_q   <= LdGap;
                    end
                    StGap: begin
                        state_q <= StLoSetup;
                        cnt_q   <= LdSetup;
                        sf_d_q  <= lo_nib_q;
                    end
                    StLoSetup: begin
                        state_q <= StLoEn;
                        cnt_q   <= LdEn;
                        en_q    <= 1'b1;
                    end
                    StLoEn: begin
                        state_q <= StLoHold;
                        cnt_q   <= LdHold;
                        en_q    <= 1'b0;
                    end
                    StLoHold: begin
                        state_q <= StWait;
                        cnt_q   <= LdWait;
                    end
                    StWait: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    default: begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx.tx_busy = busy_q;
    assign tx.tx_done = done_q;
    assign LCD_RS     = rs_q;
    assign LCD_RW     = 1'b0;
    assign LCD_EN     = en_q;
    assign LCD_SF_D   = sf_d_q;

endmodule

// File: tb/tb_lcd_nibble_tx.sv
// Scoreboard bench: default-timing DUT (index 0) and a scaled-timing DUT (index 1).
module tb_lcd_nibble_tx;

    localparam int unsigned SC [2] = '{2, 1};
    localparam int unsigned EC [2] = '{12, 2};
    localparam int unsigned HC [2] = '{1, 1};
    localparam int unsigned GC [2] = '{50, 3};
    localparam int unsigned WC [2] = '{2000, 5};

    typedef struct packed {
        logic [3:0]  nib;
        logic        rs;
        logic [31:0] off;
    } pulse_t;

    logic clk = 1'b0;
    logic rst0, rst1;
    logic rs0, rw0, en0, rs1, rw1, en1;
    logic [3:0] d0, d1;

    lcd_nibble_tx_if tx0 ();
    lcd_nibble_tx_if tx1 ();

    lcd_nibble_tx dut0 (
        .clk      (clk),
        .reset    (rst0),
        .tx       (tx0.slave),
        .LCD_RS   (rs0),
        .LCD_RW   (rw0),
        .LCD_EN   (en0),
        .LCD_SF_D (d0)
    );

    lcd_nibble_tx #(
        .SETUP_CYC (1),
        .EN_CYC    (2),
        .HOLD_CYC  (1),
        .GAP_CYC   (3),
        .WAIT_CYC  (5),
        .CNT_W     (4)
    ) dut1 (
        .clk      (clk),
        .reset    (rst1),
        .tx       (tx1.slave),
        .LCD_RS   (rs1),
        .LCD_RW   (rw1),
        .LCD_EN   (en1),
        .LCD_SF_D (d1)
    );

    always #10 clk = ~clk;

    logic       en_w [2], rs_w [2], rw_w [2], busy_w [2], done_w [2], rst_w [2];
    logic [3:0] d_w [2];
    assign en_w[0] = en0;   assign en_w[1] = en1;
    assign rs_w[0] = rs0;   assign rs_w[1] = rs1;
    assign rw_w[0] = rw0;   assign rw_w[1] = rw1;
    assign d_w[0]  = d0;    assign d_w[1]  = d1;
    assign rst_w[0] = rst0; assign rst_w[1] = rst1;
    assign busy_w[0] = tx0.tx_busy; assign busy_w[1] = tx1.tx_busy;
    assign done_w[0] = tx0.tx_done; assign done_w[1] = tx1.tx_done;

    pulse_t      pq [2][$];
    int unsigned dq [2][$];
    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned rw_bad = 0;

    task automatic check(input int d, input string nm, input int unsigned act,
                         input int unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL dut%0d %s: got %0d, expected %0d", d, nm, act, exp);
    endtask

    task automatic unexpected(input int d, input string nm);
        n_chk++;
        $display("FAIL dut%0d %s: event seen, none expected", d, nm);
    endtask

    // Monitors: pop an expectation on every EN rise and every tx_done.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        int unsigned bcnt = 0;
        int unsigned width = 0;
        logic        en_p = 1'b0;
        logic        abort = 1'b0;
        logic        stable = 1'b1;
        logic        have = 1'b0;
        logic [3:0]  nib0 = '0;
        pulse_t      cur;

        always @(negedge clk) begin
            if (rw_w[g] !== 1'b0) rw_bad++;
            if (done_w[g] === 1'b1) begin
                if (dq[g].size() == 0) unexpected(g, "tx_done");
                else check(g, "busy_len", bcnt, dq[g].pop_front());
            end
            bcnt = (busy_w[g] === 1'b1) ? bcnt + 1 : 0;
            if (en_w[g] && !en_p) begin
                width  = 1;
                nib0   = d_w[g];
                stable = 1'b1;
                abort  = 1'b0;
                have   = 1'b0;
                if (pq[g].size() == 0) unexpected(g, "en_pulse");
                else begin
                    cur  = pq[g].pop_front();
                    have = 1'b1;
                    check(g, "nibble", d_w[g], cur.nib);
                    check(g, "rs", rs_w[g], cur.rs);
                    check(g, "en_offset", bcnt, cur.off);
                end
            end else if (en_w[g] && en_p) begin
                width++;
                if (d_w[g] != nib0) stable = 1'b0;
            end else if (!en_w[g] && en_p && !abort && have) begin
                check(g, "en_width", width, EC[g]);
                check(g, "data_stable", stable, 1);
            end
            if (rst_w[g] && en_w[g]) abort = 1'b1;
            en_p = en_w[g];
        end
    end

    task automatic send(input int d, input logic [7:0] b, input logic r, input bit full);
        int unsigned up_off = SC[d] + 1;
        int unsigned lo_off = 2 * SC[d] + EC[d] + HC[d] + GC[d] + 1;
        int unsigned blen   = 2 * (SC[d] + EC[d] + HC[d]) + GC[d] + WC[d];
        pq[d].push_back('{nib: b[7:4], rs: r, off: up_off});
        if (full) begin
            pq[d].push_back('{nib: b[3:0], rs: r, off: lo_off});
            dq[d].push_back(blen);
        end
        @(posedge clk); #1;
        if (d == 0) begin tx0.tx_start = 1'b1; tx0.tx_byte = b; tx0.tx_rs = r; end
        else        begin tx1.tx_start = 1'b1; tx1.tx_byte = b; tx1.tx_rs = r; end
        @(posedge clk); #1;
        if (d == 0) tx0.tx_start = 1'b0;
        else        tx1.tx_start = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_w[d] === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(d, "done_seen", seen, 1);
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        tx0.tx_start = 1'b0; tx0.tx_byte = '0; tx0.tx_rs = 1'b0;
        tx1.tx_start = 1'b0; tx1.tx_byte = '0; tx1.tx_rs = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst0 = 1'b0; rst1 = 1'b0;

        @(negedge clk);
        check(0, "rst_en", en0, 0);
        check(0, "rst_rs", rs0, 0);
        check(0, "rst_sf_d", d0, 0);
        check(0, "rst_busy", tx0.tx_busy, 0);
        check(0, "rst_done", tx0.tx_done, 0);
        repeat (20) @(negedge clk);
        check(0, "idle_en", en0, 0);
        check(0, "idle_busy", tx0.tx_busy, 0);

        // Command byte, then data byte with an ignored mid-transfer request.
        send(0, 8'h28, 1'b0, 1'b1);
        wait_done(0, 2200);
        send(0, 8'h41, 1'b1, 1'b1);
        repeat (100) @(posedge clk);
        #1 tx0.tx_start = 1'b1; tx0.tx_byte = 8'hFF; tx0.tx_rs = 1'b0;
        @(posedge clk);
        #1 tx0.tx_start = 1'b0;
        repeat (500) @(posedge clk);

        // Hold a request across tx_done: it must start right after the done cycle.
        pq[0].push_back('{nib: 4'hF, rs: 1'b0, off: 32'd3});
        pq[0].push_back('{nib: 4'hF, rs: 1'b0, off: 32'd68});
        dq[0].push_back(2080);
        #1 tx0.tx_start = 1'b1;
        wait_done(0, 2200);
        check(0, "done_cycle_busy", tx0.tx_busy, 0);
        @(posedge clk);
        #1 tx0.tx_start = 1'b0;
        @(negedge clk);
        check(0, "b2b_busy", tx0.tx_busy, 1);
        check(0, "b2b_sf_d", d0, 4'hF);
        wait_done(0, 2200);

        // Abort during the upper enable pulse.
        send(0, 8'hC3, 1'b0, 1'b0);
        for (int i = 0; i < 50 && !en0; i++) @(negedge clk);
        repeat (4) @(posedge clk);
        #1 rst0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check(0, "abort_en", en0, 0);
        check(0, "abort_busy", tx0.tx_busy, 0);
        check(0, "abort_done", tx0.tx_done, 0);
        rst0 = 1'b0;
        repeat (10) @(negedge clk);
        send(0, 8'h01, 1'b0, 1'b1);
        wait_done(0, 2200);

        // Scaled timing instance.
        send(1, 8'hA5, 1'b0, 1'b1);
        wait_done(1, 100);
        send(1, 8'h3C, 1'b1, 1'b1);
        wait_done(1, 100);

        repeat (5) @(negedge clk);
        check(0, "pulses_left", pq[0].size(), 0);
        check(0, "dones_left", dq[0].size(), 0);
        check(1, "pulses_left", pq[1].size(), 0);
        check(1, "dones_left", dq[1].size(), 0);
        check(0, "rw_nonzero_cycles", rw_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lcd_nibble_tx.md
Name: lcd_nibble_tx

Overview:
- Byte-to-nibble transmit engine between the LCD command/initialisation FSM (upstream) and the Spartan-3E character-LCD pins (4-bit SF_D bus).
- Accepts one byte plus an RS flag per request and drives the upper then the lower nibble with HD44780-compliant setup, enable-pulse, hold, inter-nibble and post-byte delays at a 50 MHz clock.
- Reports busy and done so the upstream sequencer can issue the next command or character.

Parameters:
- SETUP_CYC, 2, cycles that RS/data are stable before LCD_EN rises (40 ns).
- EN_CYC, 12, cycles LCD_EN is held high (240 ns, at least 230 ns).
- HOLD_CYC, 1, cycles data is held after LCD_EN falls.
- GAP_CYC, 50, idle cycles between the upper and lower nibble (1 us).
- WAIT_CYC, 2000, cycles after the lower nibble before the next byte (40 us).
- CNT_W, 12, delay counter width; must satisfy 2^CNT_W > max(all *_CYC).

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- tx_start  in  1  request; sampled only when tx_busy=0
- tx_byte  in  8  byte to send; latched on accept
- tx_rs  in  1  0=command, 1=data; latched on accept
- tx_busy  out  1  high from the cycle after accept until transfer end
- tx_done  out  1  single-cycle pulse at transfer end
- LCD_RS  out  1  register select to the LCD
- LCD_RW  out  1  constant 0 (write only)
- LCD_EN  out  1  enable strobe
- LCD_SF_D  out  4  data nibble to SF_D[11:8]

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous and active-high: on a clk edge with reset=1, state←IDLE, counter←0, and LCD_EN, LCD_RS, LCD_SF_D, tx_busy, tx_done all ←0.
  - LCD_RW is 0 at all times, including during reset.
- Registered outputs:
  - All outputs are registered; no combinational path from any input to any output.
- State sequence:
  - IDLE → UP_SETUP → UP_EN → UP_HOLD → GAP → LO_SETUP → LO_EN → LO_HOLD → WAIT → IDLE.
- Accept and latch:
  - In IDLE with tx_start=1 at edge k, latch tx_byte and tx_rs.
  - From edge k+1: tx_busy=1, LCD_RS=latched rs, LCD_SF_D=byte[7:4], state UP_SETUP.
- Per-state durations (each state lasts exactly its *_CYC cycles; the counter loads on entry and the state advances when it reaches terminal count):
  - UP_SETUP/LO_SETUP: SETUP_CYC cycles, EN=0.
  - UP_EN/LO_EN: EN_CYC cycles, EN=1.
  - UP_HOLD/LO_HOLD: HOLD_CYC cycles, EN=0.
  - GAP: GAP_CYC cycles.
  - WAIT: WAIT_CYC cycles.
- Data and RS during a transfer:
  - LCD_SF_D switches to byte[3:0] on entry to LO_SETUP, never while EN=1.
  - LCD_RS is constant for the whole transfer.
- Busy duration:
  - tx_busy stays high for exactly 2*(SETUP_CYC+EN_CYC+HOLD_CYC)+GAP_CYC+WAIT_CYC cycles (2080 at defaults).
- Completion:
  - On WAIT terminal count, the next edge gives state=IDLE, tx_busy=0, tx_done=1 for one cycle.
  - LCD_SF_D and LCD_RS keep their last values until the next accept.
- Back-to-back requests:
  - tx_start=1 in the tx_done cycle is accepted; busy reasserts on the next edge.
- Ignored requests:
  - tx_start while tx_busy=1 is ignored; it is not queued and has no side effect.
  - tx_byte/tx_rs changes after accept do not affect the transfer in flight.
- Reset mid-transfer:
  - Aborts at the next edge; LCD_EN→0 immediately (a truncated EN pulse is acceptable); no tx_done pulse.
- Enable pulse count:
  - Exactly two LCD_EN pulses per accepted byte, each exactly EN_CYC cycles high.

Test Plan:
- Reset held 10 cycles, then released → all outputs 0, tx_busy=0, LCD_RW=0 throughout; no EN activity with tx_start=0.
- tx_start 1 cycle with tx_byte=8'h28, tx_rs=0 → SF_D=4'h2 for 15 cycles with EN high for cycles 3–14, GAP 50 cycles, then SF_D=4'h8 with the same timing; tx_done pulse exactly 2080 cycles after the busy rise.
- tx_byte=8'h41, tx_rs=1 → LCD_RS=1 for the whole transfer; nibbles 4'h4 then 4'h1; SF_D never changes while EN=1 (assertion).
- Second tx_start (8'hFF) pulsed mid-transfer, then tx_start held high across tx_done → mid-transfer request ignored; new transfer starts the cycle after tx_done; exactly 4 EN pulses in total.
- Reset asserted during UP_EN → next edge EN=0, busy=0, no done pulse; a new tx_start=8'h01 then completes normally.
- Scaled parameters (SETUP=1, EN=2, HOLD=1, GAP=3, WAIT=5) → busy length 16 cycles; EN pulse widths 2 cycles.
